// File: rtl/frame_min_accumulator.sv
// frame_min_accumulator
//   Reduces FRAME_LEN partial minima, one per in_beat, into one frame-wide
//   unsigned minimum. The accumulator is seeded with i_default_value when a
//   frame starts. The result is held behind a valid/ready handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for i_start; beats ignored
//   ACCUM | counting beats, folding valid values into the minimum
//   DONE  | result held stable, o_result_valid=1 until i_result_ready
//
// Ports
//   i_clk           clock, rising edge
//   i_reset         asynchronous reset, active low
//   i_start         begin a frame (accepted in IDLE, or DONE on handshake)
//   i_default_value accumulator seed, sampled on the accepted start
//   i_clear         synchronous abort to IDLE, highest priority
//   i_in_beat       a partial result is presented this cycle
//   i_in_valid      the presented partial result is meaningful
//   i_in_value      partial minimum from the upstream solver
//   o_busy          high in ACCUM and DONE
//   o_result        accumulator contents (meaningful in DONE)
//   o_any_valid     at least one beat of the frame carried i_in_valid=1
//   o_result_valid  result available
//   i_result_ready  consumer accepts the result
module frame_min_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_default_value,
  input  logic                  i_clear,
  input  logic                  i_in_beat,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_value,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_any_valid,
  output logic                  o_result_valid,
  input  logic                  i_result_ready
);

  localparam int CNT_WIDTH = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_any;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic w_handshake;
  logic w_start_acc;
  logic w_beat_acc;
  logic w_last_beat;

  assign w_handshake = (r_state == ST_DONE) && i_result_ready;
  // A new frame may start from IDLE or on the DONE handshake cycle, so
  // back-to-back frames have no idle bubble.
  assign w_start_acc = i_start && ((r_state == ST_IDLE) || w_handshake);
  assign w_beat_acc  = (r_state == ST_ACCUM) && i_in_beat;
  assign w_last_beat = w_beat_acc && (r_cnt == LAST_CNT);

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start_acc) w_state_nxt = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (w_last_beat) w_state_nxt = ST_DONE;
        end
        ST_DONE: begin
          if (w_handshake) w_state_nxt = w_start_acc ? ST_ACCUM : ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_busy         = (r_state == ST_ACCUM) || (r_state == ST_DONE);
    o_result_valid = (r_state == ST_DONE);
    o_result       = r_acc;
    o_any_valid    = r_any;
  end

  // Datapath: clear leaves the accumulator untouched, only flags and count
  // are reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_acc <= '0;
      r_any <= 1'b0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_any <= 1'b0;
      r_cnt <= '0;
    end else if (w_start_acc) begin
      r_acc <= i_default_value;
      r_any <= 1'b0;
      r_cnt <= '0;
    end else if (w_beat_acc) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
      r_any <= r_any | i_in_valid;
      // Strict less-than: a tie keeps the current value.
      if (i_in_valid && (i_in_value < r_acc)) begin
        r_acc <= i_in_value;
      end
    end
  end

endmodule

// File: tb/tb_frame_min_accumulator.sv
module tb_frame_min_accumulator;

  localparam int DW = 8;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] default_value;
  logic          clear;
  logic          in_beat;
  logic          in_valid;
  logic [DW-1:0] in_value;
  logic          busy;
  logic [DW-1:0] result;
  logic          any_valid;
  logic          result_valid;
  logic          result_ready;

  int checks = 0;
  int errors = 0;

  frame_min_accumulator #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_start        (start),
    .i_default_value(default_value),
    .i_clear        (clear),
    .i_in_beat      (in_beat),
    .i_in_valid     (in_valid),
    .i_in_value     (in_value),
    .o_busy         (busy),
    .o_result       (result),
    .o_any_valid    (any_valid),
    .o_result_valid (result_valid),
    .i_result_ready (result_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]      def;
    logic [3:0][DW-1:0] val;
    logic [3:0]         vld;
    logic [DW-1:0]      exp_res;
    logic               exp_any;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; clear = 0; in_beat = 0; in_valid = 0; in_value = '0;
    result_ready = 0; default_value = '0;
  endtask

  task automatic do_start(input logic [DW-1:0] def);
    start = 1; default_value = def;
    tick();
    start = 0;
  endtask

  task automatic do_beat(input logic [DW-1:0] v, input logic vl);
    in_beat = 1; in_valid = vl; in_value = v;
    tick();
    in_beat = 0; in_valid = 0;
  endtask

  // Reference model: a frame is a seed plus the list of valid values seen;
  // the expected result is the smallest of them.
  int            m_phase;  // 0 idle, 1 collecting, 2 holding
  logic [DW-1:0] m_seed;
  logic [DW-1:0] m_vals[$];
  logic          m_any;
  int            m_n;

  function automatic logic [DW-1:0] m_result();
    logic [DW-1:0] r = m_seed;
    foreach (m_vals[k]) if (m_vals[k] < r) r = m_vals[k];
    return r;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_seed = '0; m_vals.delete(); m_any = 0; m_n = 0;
  endtask

  task automatic m_new_frame();
    m_phase = 1; m_seed = default_value; m_vals.delete(); m_any = 0; m_n = 0;
  endtask

  task automatic m_step();
    if (clear) begin
      m_phase = 0; m_any = 0; m_n = 0;
    end else if (m_phase == 0) begin
      if (start) m_new_frame();
    end else if (m_phase == 1) begin
      if (in_beat) begin
        m_n++;
        if (in_valid) begin m_vals.push_back(in_value); m_any = 1; end
        if (m_n == FL) m_phase = 2;
      end
    end else begin
      if (result_ready) begin
        if (start) m_new_frame();
        else m_phase = 0;
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_rv", result_valid, 0);
    check("reset_result", result, 0);
    check("reset_any", any_valid, 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("idle_busy", busy, 0);
    check("idle_rv", result_valid, 0);
    check("idle_result", result, 8'h00);
    check("idle_any", any_valid, 0);

    // Table-driven frames, beats back to back, exact latency
    vecs[0] = '{def: 8'h33, val: {8'h00, 8'h00, 8'h00, 8'h00}, vld: 4'b0000, exp_res: 8'h33, exp_any: 1'b0};
    vecs[1] = '{def: 8'h33, val: {8'h88, 8'h05, 8'h11, 8'h44}, vld: 4'b1011, exp_res: 8'h11, exp_any: 1'b1};
    vecs[2] = '{def: 8'h10, val: {8'h10, 8'h10, 8'h10, 8'h10}, vld: 4'b1111, exp_res: 8'h10, exp_any: 1'b1};
    vecs[3] = '{def: 8'h00, val: {8'h02, 8'h01, 8'h80, 8'hFF}, vld: 4'b1111, exp_res: 8'h00, exp_any: 1'b1};
    vecs[4] = '{def: 8'h80, val: {8'hA0, 8'h7F, 8'h7F, 8'h90}, vld: 4'b0010, exp_res: 8'h7F, exp_any: 1'b1};
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].def);
      check($sformatf("v%0d_busy_accum", v), busy, 1);
      for (int b = 0; b < FL; b++) begin
        if (b == FL - 1) check($sformatf("v%0d_rv_early", v), result_valid, 0);
        do_beat(vecs[v].val[b], vecs[v].vld[b]);
      end
      check($sformatf("v%0d_rv", v), result_valid, 1);
      check($sformatf("v%0d_result", v), result, vecs[v].exp_res);
      check($sformatf("v%0d_any", v), any_valid, vecs[v].exp_any);
      result_ready = 1;
      tick();
      result_ready = 0;
      check($sformatf("v%0d_rv_drop", v), result_valid, 0);
      check($sformatf("v%0d_busy_idle", v), busy, 0);
    end

    // Gapped beats, stalled consumer, stray beats in DONE
    do_start(8'hFF);
    begin
      logic [DW-1:0] gv[4];
      gv[0] = 8'hFF; gv[1] = 8'hFE; gv[2] = 8'hFD; gv[3] = 8'hFB;
      for (int b = 0; b < 4; b++) begin
        do_beat(gv[b], 1);
        if (b < 3) begin tick(); tick(); end
      end
    end
    for (int s = 0; s < 3; s++) begin
      in_beat = 1; in_valid = 1; in_value = 8'h00;
      check("stall_rv", result_valid, 1);
      check("stall_result", result, 8'hFB);
      tick();
    end
    in_beat = 0; in_valid = 0;
    check("stall_result_end", result, 8'hFB);
    check("stall_any", any_valid, 1);
    result_ready = 1;
    tick();
    result_ready = 0;
    check("stall_idle", busy, 0);

    // Back-to-back frame on the handshake cycle
    do_start(8'h20);
    for (int b = 0; b < FL; b++) do_beat(8'h05, 1);
    check("b2b_first", result, 8'h05);
    result_ready = 1; start = 1; default_value = 8'hAA;
    tick();
    result_ready = 0; start = 0;
    check("b2b_busy", busy, 1);
    check("b2b_rv_low", result_valid, 0);
    check("b2b_seed", result, 8'hAA);
    for (int b = 0; b < FL; b++) do_beat(8'h01, 0);
    check("b2b_rv", result_valid, 1);
    check("b2b_result", result, 8'hAA);
    check("b2b_any", any_valid, 0);
    result_ready = 1; tick(); result_ready = 0;

    // Clear after two beats; accumulator left as-is
    do_start(8'h50);
    do_beat(8'h40, 1);
    do_beat(8'h30, 1);
    clear = 1; start = 1;
    tick();
    clear = 0; start = 0;
    check("clr_busy", busy, 0);
    check("clr_rv", result_valid, 0);
    check("clr_any", any_valid, 0);
    check("clr_acc_kept", result, 8'h30);
    do_start(8'h77);
    do_beat(8'h60, 1); do_beat(8'h61, 1); do_beat(8'h62, 0); do_beat(8'h70, 1);
    check("clr_after_rv", result_valid, 1);
    check("clr_after_result", result, 8'h60);
    result_ready = 1; tick(); result_ready = 0;

    // Asynchronous reset mid-frame, between edges
    do_start(8'h90);
    do_beat(8'h10, 1);
    do_beat(8'h20, 1);
    #2 rst_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rv", result_valid, 0);
    check("arst_result", result, 8'h00);
    check("arst_any", any_valid, 0);
    #2 rst_n = 1;
    tick();

    // Randomized traffic against the frame-level model
    m_reset();
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      check("rnd_busy", busy, (m_phase != 0));
      check("rnd_rv", result_valid, (m_phase == 2));
      check("rnd_result", result, m_result());
      check("rnd_any", any_valid, m_any);
      start         = ($urandom_range(0, 3) == 0);
      default_value = DW'($urandom);
      clear         = ($urandom_range(0, 40) == 0);
      in_beat       = ($urandom_range(0, 2) != 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_value      = ($urandom_range(0, 1) == 0) ? DW'($urandom) : DW'($urandom_range(0, 7));
      result_ready  = ($urandom_range(0, 2) == 0);
      m_step();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
